// File: rtl/irq_defs_pkg.sv
// Shared definitions for the interrupt controller: default line count and FSM encoding.
package irq_defs;

  localparam int DEFAULT_N_IRQ = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational priority encoder: lowest set bit index wins, plus an any-set flag.
module irq_priority_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_bits,
  output logic [W-1:0] o_index,
  output logic         o_any
);

  always_comb begin
    o_index = '0;
    o_any   = |i_bits;
    // Scan downward so the last assignment is the lowest set index.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_bits[i]) o_index = W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Registered interrupt controller: edge-detected pending latch, enable mask,
// fixed priority selection and a request/service handshake with the CPU.
module interrupt_controller
  import irq_defs::*;
#(
  parameter int                   N_IRQ      = DEFAULT_N_IRQ,
  parameter int                   VEC_W      = $clog2(N_IRQ),
  parameter logic [N_IRQ-1:0]     MASK_RESET = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic [N_IRQ-1:0] mask,
  output logic [N_IRQ-1:0] pending,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vector,
  input  logic             int_ack,
  input  logic             int_eoi,
  output logic             in_service
);

  localparam logic [N_IRQ-1:0] ONE = {{(N_IRQ-1){1'b0}}, 1'b1};

  logic [N_IRQ-1:0] r_irq_prev;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic             r_int_req;
  logic [VEC_W-1:0] r_int_vector;
  logic             r_in_service;
  irq_state_t       r_state;

  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] w_active;
  logic [N_IRQ-1:0] w_clr;
  logic             w_ack_ok;
  logic [VEC_W-1:0] w_prio;
  logic             w_any;

  irq_state_t       w_state_next;
  logic             w_req_next;
  logic [VEC_W-1:0] w_vec_next;
  logic             w_insvc_next;

  assign w_edge   = irq_in & ~r_irq_prev;
  assign w_active = r_pending & r_mask;
  assign w_ack_ok = (r_state == REQ) && int_ack;
  assign w_clr    = w_ack_ok ? (ONE << r_int_vector) : '0;

  irq_priority_encoder #(
    .N (N_IRQ),
    .W (VEC_W)
  ) u_prio (
    .i_bits  (w_active),
    .o_index (w_prio),
    .o_any   (w_any)
  );

  // Edge detect, pending latch and mask; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_mask     <= MASK_RESET;
    end else begin
      r_irq_prev <= irq_in;
      r_pending  <= (r_pending & ~w_clr) | w_edge;
      if (mask_we) r_mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_int_req    <= 1'b0;
      r_int_vector <= '0;
      r_in_service <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_int_req    <= w_req_next;
      r_int_vector <= w_vec_next;
      r_in_service <= w_insvc_next;
    end
  end

  // Once a request is latched it is held until ack, ignoring later arrivals and mask edits.
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_int_req;
    w_vec_next   = r_int_vector;
    w_insvc_next = r_in_service;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_vec_next   = w_prio;
          w_req_next   = 1'b1;
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (int_ack) begin
          w_req_next   = 1'b0;
          w_insvc_next = 1'b1;
          w_state_next = SERVICE;
        end
      end
      SERVICE: begin
        if (int_eoi) begin
          w_insvc_next = 1'b0;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_req_next   = 1'b0;
        w_insvc_next = 1'b0;
      end
    endcase
  end

  assign mask       = r_mask;
  assign pending    = r_pending;
  assign int_req    = r_int_req;
  assign int_vector = r_int_vector;
  assign in_service = r_in_service;

endmodule
